// File: rtl/fmul_pipe.sv
// fmul_pipe: three-stage pipelined floating-point multiplier with valid/ready
// flow control, round-to-nearest-even, flush-to-zero and overflow saturation.
// A sideband tag travels alongside each operand pair and returns with its result.
// Optional feature macro: FMUL_PIPE_SPECIAL_EN decodes inf/NaN operands as IEEE
// specials; without it, all-ones exponents are treated as ordinary numbers.
module fmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] x1,
    input  logic [EXP_W+MAN_W:0] x2,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] y,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 1;
    localparam int LO_W = (MW * 3) / 4;
    localparam int HI_W = MW - LO_W;
    localparam int EW2  = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;

    // Operand field split; the hidden leading one is made explicit.
    logic             s1, s2;
    logic [EXP_W-1:0] e1, e2;
    logic [MW-1:0]    m1, m2;
    assign {s1, e1} = x1[W-1:MAN_W];
    assign {s2, e2} = x2[W-1:MAN_W];
    assign m1 = {1'b1, x1[MAN_W-1:0]};
    assign m2 = {1'b1, x2[MAN_W-1:0]};

    // Stage advance chain: a stage moves when the stage ahead is empty or moving.
    logic v1_q, v2_q, v3_q;
    logic adv1, adv2, adv3, accept;
    assign adv3      = ~v3_q | out_ready;
    assign adv2      = ~v2_q | adv3;
    assign adv1      = ~v1_q | adv2;
    assign in_ready  = adv3;
    assign accept    = in_valid & in_ready;
    assign out_valid = v3_q;

    // Stage 1 next-state: split partial products, exponent sum, sign, zero flag.
    logic [MW+HI_W-1:0] ppHi_d, ppHi_q;
    logic [MW+LO_W-1:0] ppLo_d, ppLo_q;
    logic [EW2-1:0]     esum_d, esum_q;
    logic               sign_d, sign1_q, zero_d, zero1_q;
    logic [TAG_W-1:0]   tag1_q, tag2_q, tag3_q;
    assign ppHi_d = {{HI_W{1'b0}}, m1} * {{MW{1'b0}}, m2[MW-1:LO_W]};
    assign ppLo_d = {{LO_W{1'b0}}, m1} * {{MW{1'b0}}, m2[LO_W-1:0]};
    assign esum_d = {2'b00, e1} + {2'b00, e2};
    assign sign_d = s1 ^ s2;
    assign zero_d = (e1 == '0) | (e2 == '0);

`ifdef FMUL_PIPE_SPECIAL_EN
    typedef enum logic [1:0] {CLS_NUM, CLS_INF, CLS_NAN} cls_e;
    cls_e cls_d, cls1_q, cls2_q;
    logic inf1, inf2, nan1, nan2;
    assign inf1 = (e1 == '1) & (x1[MAN_W-1:0] == '0);
    assign inf2 = (e2 == '1) & (x2[MAN_W-1:0] == '0);
    assign nan1 = (e1 == '1) & (x1[MAN_W-1:0] != '0);
    assign nan2 = (e2 == '1) & (x2[MAN_W-1:0] != '0);

    // Special class: any NaN or inf*zero gives NaN, otherwise any inf gives inf.
    always_comb begin
        cls_d = CLS_NUM;
        if (nan1 | nan2 | ((inf1 | inf2) & zero_d)) begin
            cls_d = CLS_NAN;
        end else if (inf1 | inf2) begin
            cls_d = CLS_INF;
        end
    end
`endif

    // Stage 1 register: captures a new operand pair on accept, empties otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q    <= 1'b0;
            ppHi_q  <= '0;
            ppLo_q  <= '0;
            esum_q  <= '0;
            sign1_q <= 1'b0;
            zero1_q <= 1'b0;
            tag1_q  <= '0;
`ifdef FMUL_PIPE_SPECIAL_EN
            cls1_q  <= CLS_NUM;
`endif
        end else if (adv1) begin
            v1_q <= accept;
            if (accept) begin
                ppHi_q  <= ppHi_d;
                ppLo_q  <= ppLo_d;
                esum_q  <= esum_d;
                sign1_q <= sign_d;
                zero1_q <= zero_d;
                tag1_q  <= in_tag;
`ifdef FMUL_PIPE_SPECIAL_EN
                cls1_q  <= cls_d;
`endif
            end
        end
    end

    // Stage 2 next-state: full product, normalise into [1,2), guard and sticky.
    logic [2*MW-1:0]  prod;
    logic [2*MW-2:0]  norm;
    logic             top;
    logic [MAN_W-1:0] man_d, man2_q;
    logic             guard_d, guard2_q, sticky_d, sticky2_q;
    logic [EW2-1:0]   exp_d, exp2_q;
    logic             sign2_q, zero2_q;
    assign prod     = {ppHi_q, {LO_W{1'b0}}} + {{HI_W{1'b0}}, ppLo_q};
    assign top      = prod[2*MW-1];
    assign norm     = top ? prod[2*MW-2:0] : {prod[2*MW-3:0], 1'b0};
    assign man_d    = norm[2*MW-2 -: MAN_W];
    assign guard_d  = norm[MAN_W];
    assign sticky_d = |norm[MAN_W-1:0];
    assign exp_d    = esum_q + {{(EW2-1){1'b0}}, top} - EW2'(BIAS);

    // Stage 2 register: holds the normalised, not yet rounded product.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2_q      <= 1'b0;
            man2_q    <= '0;
            guard2_q  <= 1'b0;
            sticky2_q <= 1'b0;
            exp2_q    <= '0;
            sign2_q   <= 1'b0;
            zero2_q   <= 1'b0;
            tag2_q    <= '0;
`ifdef FMUL_PIPE_SPECIAL_EN
            cls2_q    <= CLS_NUM;
`endif
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                man2_q    <= man_d;
                guard2_q  <= guard_d;
                sticky2_q <= sticky_d;
                exp2_q    <= exp_d;
                sign2_q   <= sign1_q;
                zero2_q   <= zero1_q;
                tag2_q    <= tag1_q;
`ifdef FMUL_PIPE_SPECIAL_EN
                cls2_q    <= cls1_q;
`endif
            end
        end
    end

    // Stage 3 next-state: round to nearest even, renormalise on carry-out.
    logic             up;
    logic [MAN_W:0]   manR;
    logic [EW2-1:0]   expR;
    logic [W-1:0]     y_d, y3_q;
    assign up   = guard2_q & (sticky2_q | man2_q[0]);
    assign manR = {1'b0, man2_q} + {{MAN_W{1'b0}}, up};
    assign expR = exp2_q + {{(EW2-1){1'b0}}, manR[MAN_W]};

    // Range check and pack; zero/underflow flush and overflow saturation keep the sign.
    always_comb begin
        y_d = {sign2_q, expR[EXP_W-1:0], manR[MAN_W-1:0]};
        if (zero2_q || expR[EW2-1] || expR == '0) begin
            y_d = {sign2_q, {(W-1){1'b0}}};
        end else if (expR >= EW2'(EMAX)) begin
            y_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
`ifdef FMUL_PIPE_SPECIAL_EN
        if (cls2_q == CLS_NAN) begin
            y_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (cls2_q == CLS_INF) begin
            y_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
`endif
    end

    // Stage 3 register: output holding register, frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v3_q   <= 1'b0;
            y3_q   <= '0;
            tag3_q <= '0;
        end else if (adv3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                y3_q   <= y_d;
                tag3_q <= tag2_q;
            end
        end
    end

    assign y       = y3_q;
    assign out_tag = tag3_q;
endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: directed vector table plus hand-written backpressure and
// mid-flight reset sequences for fmul_pipe at default widths.
`timescale 1ns/1ps
module tb_fmul_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 5;
    localparam int NVEC  = 17;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [31:0]       x1, x2, y;
    logic [TAG_W-1:0]  in_tag, out_tag;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expY;
    } vec_t;
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    fmul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .out_tag(out_tag)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Presents one operand pair for exactly one clock edge (called at posedge+1).
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        x1 = a;
        x2 = b;
        in_tag = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Sends one pair, waits (bounded) for its result, checks value and tag, drains it.
    task automatic runVector(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [TAG_W-1:0] tag, input logic [31:0] expY, output int lat);
        out_ready = 1'b1;
        applyStimulus(a, b, tag);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({name, " valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, " y"}, y, expY);
        checkOutput({name, " tag"}, 32'(out_tag), 32'(tag));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int sent, got, cyc, seen;
        logic acc, fire;
        logic [31:0] bpA[8];
        logic [31:0] bpExp[8];

        vecs[0]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002};
        vecs[1]  = '{32'hBF800000, 32'h3F800000, 32'hBF800000};
        vecs[2]  = '{32'h00800000, 32'h00800000, 32'h00000000};
        vecs[3]  = '{32'h7F000000, 32'h40000000, 32'h7F800000};
        vecs[4]  = '{32'h80000000, 32'h3F800000, 32'h80000000};
        vecs[5]  = '{32'h40400000, 32'h40400000, 32'h41100000};
        vecs[6]  = '{32'hC0000000, 32'hC0000000, 32'h40800000};
        vecs[7]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002};
        vecs[8]  = '{32'h3FFFFFFF, 32'h3F800001, 32'h40000000};
        vecs[9]  = '{32'h7F7FFFFF, 32'h3F800001, 32'h7F800000};
        vecs[10] = '{32'h20000000, 32'h1F800000, 32'h00000000};
        vecs[11] = '{32'h20000000, 32'h20000000, 32'h00800000};
        vecs[12] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004};
        vecs[13] = '{32'h7F800000, 32'h3F800000, 32'h7F800000};
        vecs[14] = '{32'hFF800000, 32'h40000000, 32'hFF800000};
`ifdef FMUL_PIPE_SPECIAL_EN
        vecs[15] = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
        vecs[16] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000};
`else
        vecs[15] = '{32'h7F800000, 32'h00000000, 32'h00000000};
        vecs[16] = '{32'h7FC00000, 32'h3F800000, 32'h7F800000};
`endif
        bpA   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        bpExp = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                  32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

        // Reset state.
        rstn = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x1 = '0;
        x2 = '0;
        in_tag = '0;
        #12;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset y", y, 32'd0);
        checkOutput("reset out_tag", 32'(out_tag), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic product; two further edges after the accept edge means the
        // result is visible in the third cycle after the accept cycle.
        runVector("basic", 32'h3FC00000, 32'h40000000, 5'd3, 32'h40400000, lat);
        checkOutput("basic latency", 32'(lat), 32'd2);

        $display("[TB] applying %0d table vectors", NVEC);
        for (int i = 0; i < NVEC; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, TAG_W'(i), vecs[i].expY, lat);
        end

        // Backpressure: 8 back-to-back pairs, consumer stalls for 5 cycles mid-stream.
        $display("[TB] backpressure stream");
        sent = 0;
        got = 0;
        cyc = 0;
        while ((sent < 8 || got < 8) && cyc < 80) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            if (sent < 8) begin
                in_valid = 1'b1;
                x1 = bpA[sent];
                x2 = 32'h40000000;
                in_tag = TAG_W'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #2;
            acc = in_valid & in_ready;
            fire = out_valid & out_ready;
            if (out_valid && !out_ready) begin
                checkOutput($sformatf("bp in_ready cyc%0d", cyc), 32'(in_ready), 32'd0);
            end
            if (out_valid) begin
                if (got < 8) begin
                    checkOutput($sformatf("bp y cyc%0d", cyc), y, bpExp[got]);
                    checkOutput($sformatf("bp tag cyc%0d", cyc), 32'(out_tag), 32'(got));
                end else begin
                    checkOutput("bp extra result", 32'(out_valid), 32'd0);
                end
            end
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (fire) got++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checkOutput("bp accepted", 32'(sent), 32'd8);
        checkOutput("bp delivered", 32'(got), 32'd8);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        checkOutput("bp no duplicates", 32'(seen), 32'd0);

        // Reset with two pairs in flight (one in stage 2, one in stage 1).
        $display("[TB] reset mid-flight");
        applyStimulus(32'h3F800000, 32'h40400000, 5'd9);
        applyStimulus(32'h40000000, 32'h40400000, 5'd10);
        rstn = 1'b0;
        #1;
        checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset y", y, 32'd0);
        checkOutput("midreset out_tag", 32'(out_tag), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        checkOutput("midreset results discarded", 32'(seen), 32'd0);
        runVector("post-reset", 32'h40400000, 32'h40000000, 5'd11, 32'h40C00000, lat);
        checkOutput("post-reset latency", 32'(lat), 32'd2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
